// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit:
// funct3 codes, FSM states and request legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } lsu_state_t;

    // Misaligned, unsupported or out-of-range requests never reach memory
    function automatic logic lsu_req_err(
        input logic        we,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] mem_bytes
    );
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr[0];
            F3_W:    bad = (addr[1:0] != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | addr[0];
            default: bad = 1'b1;
        endcase
        if (addr >= mem_bytes) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle and Data_Memory bus bundle.
// master drives the request (core) or the memory address/data (LSU).
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if;
    logic        mem_WE;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    modport master (
        output mem_WE, mem_A, mem_WD,
        input  mem_RD
    );
    modport slave (
        input  mem_WE, mem_A, mem_WD,
        output mem_RD
    );
endinterface

// File: rtl/lsu_align.sv
// Lane selection and extension for loads, lane merge for
// sub-word stores. Purely combinational, little-endian.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] mem_word_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Extract and extend the addressed lane of the memory word
    always_comb begin
        byte_sel  = mem_word_i[{addr_i, 3'b000} +: 8];
        half_sel  = addr_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];
        ld_data_o = mem_word_i;
        case (funct3_i)
            F3_B:    ld_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data_o = {24'd0, byte_sel};
            F3_H:    ld_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_data_o = {16'd0, half_sel};
            default: ld_data_o = mem_word_i;
        endcase
    end

    // Overlay store data onto the old word at the addressed lane
    always_comb begin
        st_word_o = mem_word_i;
        case (funct3_i)
            F3_B: begin
                st_word_o[{addr_i, 3'b000} +: 8] = st_data_i[7:0];
            end
            F3_H: begin
                if (addr_i[1]) begin
                    st_word_o[31:16] = st_data_i[15:0];
                end else begin
                    st_word_o[15:0] = st_data_i[15:0];
                end
            end
            default: st_word_o = st_data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Sequencer between the memory stage and a word-only Data_Memory.
// Sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic      clk,
    input  logic      rst,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    lsu_state_t  state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] merge_q;

    logic        ready;
    logic        wr_en;
    logic        resp_v;
    logic        req_err;
    logic        accept;
    logic [31:0] ld_data;
    logic [31:0] st_word;

    assign req_err = lsu_req_err(req.req_we, req.req_funct3,
                                 req.req_addr, 32'(MEM_BYTES));
    assign accept  = req.req_valid & ready;

    lsu_align u_align (
        .funct3_i   (f3_q),
        .addr_i     (addr_q[1:0]),
        .mem_word_i (mem.mem_RD),
        .st_data_i  (wdata_q),
        .ld_data_o  (ld_data),
        .st_word_o  (st_word)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        wr_en   = 1'b0;
        resp_v  = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (req.req_valid) begin
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (!req.req_we) begin
                        state_d = S_LOAD;
                    end else if (req.req_funct3 == F3_W) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LOAD:   state_d = S_RESP;
            S_RMW_RD: state_d = S_WRITE;
            S_WRITE: begin
                wr_en   = we_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                resp_v  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request latches, load result and merge register
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            merge_q <= 32'd0;
        end else begin
            if (accept) begin
                we_q    <= req.req_we;
                f3_q    <= req.req_funct3;
                addr_q  <= req.req_addr;
                wdata_q <= req.req_wdata;
                err_q   <= req_err;
                rdata_q <= 32'd0;
                merge_q <= req.req_wdata;
            end
            if (state_q == S_LOAD) begin
                rdata_q <= ld_data;
            end
            if (state_q == S_RMW_RD) begin
                merge_q <= st_word;
            end
        end
    end

    assign req.req_ready  = ready;
    assign req.resp_valid = resp_v;
    assign req.resp_rdata = resp_v ? rdata_q : 32'd0;
    assign req.resp_err   = resp_v & err_q;

    // Write strobe is masked by reset so an in-flight store is dropped
    assign mem.mem_WE = wr_en & rst;
    assign mem.mem_A  = {addr_q[31:2], 2'b00};
    assign mem.mem_WD = (state_q == S_WRITE) ? merge_q : 32'd0;

endmodule
